// File: rtl/carry_save_resolver_pkg.sv
// carry_save_resolver_pkg
// Shared definitions for the carry-save resolver: the controller state
// encoding and the elaboration-time helpers that size the chunk loop.
// No ports (package).

package carry_save_resolver_pkg;

    // Controller states: waiting for a pair, walking the chunks, holding a result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of CHUNK-wide slices needed to cover the N+2 bit working width
    function automatic int num_chunks(input int n, input int chunk);
        return (n + 2 + chunk - 1) / chunk;
    endfunction

    // Width of the chunk index counter; a single chunk still needs one bit
    function automatic int idx_width(input int n, input int chunk);
        int k;
        k = num_chunks(n, chunk);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/carry_save_resolver_chunk_adder.sv
// csr_chunk_adder
// Purely combinational CHUNK-bit ripple adder used as the per-cycle
// slice of the resolver's carry-propagate add.
// Ports:
//   a_i    [CHUNK-1:0]  first operand slice
//   b_i    [CHUNK-1:0]  second operand slice
//   cin_i               carry from the previous slice
//   s_o    [CHUNK-1:0]  slice sum
//   cout_o              carry into the next slice

module csr_chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o
);

    // Extend everything by one bit so the carry-out lands in the top bit
    assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/carry_save_resolver.sv
// carry_save_resolver
// Collapses a carry-save pair (sum vector, carry vector weighted one place
// higher) into a plain binary number using a chunked carry-propagate add
// that resolves CHUNK bits per clock. Valid/ready handshakes on both sides.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair (registered)
//   sum_vec    [N-1:0] CSA sum vector, bit i weight 2^i
//   carry_vec  [N-1:0] CSA carry vector, bit i weight 2^(i+1)
//   out_valid  result valid (registered)
//   out_ready  downstream accepts the result
//   result     [N+1:0] sum_vec + (carry_vec << 1) (registered)
//   busy       high while chunks are being resolved (registered)

module carry_save_resolver
    import carry_save_resolver_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] sum_vec,
    input  logic [N-1:0] carry_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N+1:0] result,
    output logic         busy
);

    localparam int W  = N + 2;
    localparam int K  = num_chunks(N, CHUNK);
    localparam int PW = K * CHUNK;
    localparam int IW = idx_width(N, CHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    state_e          state_q;
    logic [PW-1:0]   opA_q;
    logic [PW-1:0]   opB_q;
    logic [PW-1:0]   result_q;
    logic [IW-1:0]   idx_q;
    logic            cin_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    int              shiftAmt;
    logic [CHUNK-1:0] chunkA;
    logic [CHUNK-1:0] chunkB;
    logic [CHUNK-1:0] chunkSum_d;
    logic             chunkCarry_d;
    logic [PW-1:0]    result_d;

    // Pick out the operand slices for the current chunk and merge the slice
    // sum into its slot of the result. The result register is cleared on
    // accept, so OR-ing the shifted slice in is enough to place it.
    always_comb begin
        shiftAmt = CHUNK * int'(idx_q);
        chunkA   = CHUNK'(opA_q >> shiftAmt);
        chunkB   = CHUNK'(opB_q >> shiftAmt);
        result_d = result_q | (PW'(chunkSum_d) << shiftAmt);
    end

    csr_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i    (chunkA),
        .b_i    (chunkB),
        .cin_i  (cin_q),
        .s_o    (chunkSum_d),
        .cout_o (chunkCarry_d)
    );

    // Controller, datapath registers and registered handshake outputs.
    // The carry vector is latched already shifted up one place so both
    // operands share the same bit weights; bits above W stay zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            cin_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        opA_q      <= PW'(sum_vec);
                        opB_q      <= PW'({carry_vec, 1'b0});
                        result_q   <= '0;
                        idx_q      <= '0;
                        cin_q      <= 1'b0;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                BUSY: begin
                    result_q <= result_d;
                    cin_q    <= chunkCarry_d;
                    idx_q    <= idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE here (not accepting) keeps the
                    // output and input handshakes in separate cycles
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q[W-1:0];

endmodule

// File: tb/tb_carry_save_resolver.sv
// tb_carry_save_resolver
// Directed and stress bench for carry_save_resolver across four
// parameterisations: (8,4) directed, (1,1) and (4,16) exhaustive,
// (8,3) random handshake stress with an in-order scoreboard.

module tb_carry_save_resolver;

    logic clk;
    logic rst_n;

    logic       inValidA, inReadyA, outValidA, outReadyA, busyA;
    logic [7:0] sumA, carryA;
    logic [9:0] resultA;

    logic       inValidB, inReadyB, outValidB, outReadyB, busyB;
    logic [0:0] sumB, carryB;
    logic [2:0] resultB;

    logic       inValidC, inReadyC, outValidC, outReadyC, busyC;
    logic [3:0] sumC, carryC;
    logic [5:0] resultC;

    logic       inValidD, inReadyD, outValidD, outReadyD, busyD;
    logic [7:0] sumD, carryD;
    logic [9:0] resultD;

    int checks = 0;
    int passes = 0;

    logic [9:0] expQ[$];
    int sent     = 0;
    int received = 0;

    carry_save_resolver #(.N(8), .CHUNK(4)) dutA (
        .clk(clk), .rst_n(rst_n), .in_valid(inValidA), .in_ready(inReadyA),
        .sum_vec(sumA), .carry_vec(carryA), .out_valid(outValidA),
        .out_ready(outReadyA), .result(resultA), .busy(busyA)
    );

    carry_save_resolver #(.N(1), .CHUNK(1)) dutB (
        .clk(clk), .rst_n(rst_n), .in_valid(inValidB), .in_ready(inReadyB),
        .sum_vec(sumB), .carry_vec(carryB), .out_valid(outValidB),
        .out_ready(outReadyB), .result(resultB), .busy(busyB)
    );

    carry_save_resolver #(.N(4), .CHUNK(16)) dutC (
        .clk(clk), .rst_n(rst_n), .in_valid(inValidC), .in_ready(inReadyC),
        .sum_vec(sumC), .carry_vec(carryC), .out_valid(outValidC),
        .out_ready(outReadyC), .result(resultC), .busy(busyC)
    );

    carry_save_resolver #(.N(8), .CHUNK(3)) dutD (
        .clk(clk), .rst_n(rst_n), .in_valid(inValidD), .in_ready(inReadyD),
        .sum_vec(sumD), .carry_vec(carryD), .out_valid(outValidD),
        .out_ready(outReadyD), .result(resultD), .busy(busyD)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        else
            passes++;
    endtask

    // Drive the input side of one of the directed instances
    task automatic applyStimulus(input int d, input logic v, input logic [31:0] s,
                                 input logic [31:0] c);
        case (d)
            0: begin inValidA = v; sumA = s[7:0]; carryA = c[7:0]; end
            1: begin inValidB = v; sumB = s[0:0]; carryB = c[0:0]; end
            default: begin inValidC = v; sumC = s[3:0]; carryC = c[3:0]; end
        endcase
    endtask

    task automatic setOutReady(input int d, input logic r);
        case (d)
            0: outReadyA = r;
            1: outReadyB = r;
            default: outReadyC = r;
        endcase
    endtask

    // what: 0 in_ready, 1 out_valid, 2 busy, 3 result
    function automatic logic [31:0] probe(input int d, input int what);
        logic [31:0] r;
        r = '0;
        case (d)
            0: case (what)
                   0: r = 32'(inReadyA);
                   1: r = 32'(outValidA);
                   2: r = 32'(busyA);
                   default: r = 32'(resultA);
               endcase
            1: case (what)
                   0: r = 32'(inReadyB);
                   1: r = 32'(outValidB);
                   2: r = 32'(busyB);
                   default: r = 32'(resultB);
               endcase
            default: case (what)
                   0: r = 32'(inReadyC);
                   1: r = 32'(outValidC);
                   2: r = 32'(busyC);
                   default: r = 32'(resultC);
               endcase
        endcase
        return r;
    endfunction

    // One full transaction: accept, measure latency and busy cycles,
    // check the result, then complete the output handshake
    task automatic runTrans(input int d, input logic [31:0] s, input logic [31:0] c,
                            input logic [31:0] expV, input int k, input string name);
        int edges;
        int busyCnt;
        logic [31:0] ov;
        @(negedge clk);
        checkOutput({name, ".inReady"}, probe(d, 0), 32'd1);
        applyStimulus(d, 1'b1, s, c);
        edges = 0;
        busyCnt = 0;
        do begin
            @(negedge clk);
            edges++;
            if (edges == 1) applyStimulus(d, 1'b0, ~s, ~c);
            ov = probe(d, 1);
            if (ov == 0) busyCnt += int'(probe(d, 2));
        end while (ov == 0 && edges < 64);
        checkOutput({name, ".latency"}, 32'(edges - 1), 32'(k));
        checkOutput({name, ".busyCycles"}, 32'(busyCnt), 32'(k));
        checkOutput({name, ".result"}, probe(d, 3), expV);
        setOutReady(d, 1'b1);
        @(negedge clk);
        setOutReady(d, 1'b0);
        checkOutput({name, ".outValidDrop"}, probe(d, 1), 32'd0);
        checkOutput({name, ".inReadyBack"}, probe(d, 0), 32'd1);
    endtask

    initial begin
        int waitCnt;
        logic [31:0] sv, cv;
        rst_n = 1'b1;
        inValidA = 0; sumA = 0; carryA = 0; outReadyA = 0;
        inValidB = 0; sumB = 0; carryB = 0; outReadyB = 0;
        inValidC = 0; sumC = 0; carryC = 0; outReadyC = 0;
        inValidD = 0; sumD = 0; carryD = 0; outReadyD = 0;

        // Reset state
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset.inReady", 32'(inReadyA), 32'd1);
        checkOutput("reset.outValid", 32'(outValidA), 32'd0);
        checkOutput("reset.busy", 32'(busyA), 32'd0);
        checkOutput("reset.result", 32'(resultA), 32'd0);
        rst_n = 1'b1;

        // Directed N=8, CHUNK=4
        runTrans(0, 32'hFF, 32'hFF, 32'h2FD, 3, "A_allOnes");
        runTrans(0, 32'h0F, 32'h01, 32'h011, 3, "A_chunkCarry");
        runTrans(0, 32'h00, 32'h00, 32'h000, 3, "A_zero");

        // Backpressure: result held, no accept until back in IDLE
        @(negedge clk);
        applyStimulus(0, 1'b1, 32'h12, 32'h34);
        @(negedge clk);
        applyStimulus(0, 1'b1, 32'h55, 32'h0A);
        waitCnt = 0;
        while (!outValidA && waitCnt < 64) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("bp.firstResult", 32'(resultA), 32'h07A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp.resultHeld", 32'(resultA), 32'h07A);
            checkOutput("bp.inReadyLow", 32'(inReadyA), 32'd0);
            checkOutput("bp.outValidHeld", 32'(outValidA), 32'd1);
        end
        outReadyA = 1'b1;
        @(negedge clk);
        outReadyA = 1'b0;
        checkOutput("bp.idleOutValid", 32'(outValidA), 32'd0);
        checkOutput("bp.idleInReady", 32'(inReadyA), 32'd1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 32'h00, 32'h00);
        checkOutput("bp.secondAccepted", 32'(busyA), 32'd1);
        waitCnt = 0;
        while (!outValidA && waitCnt < 64) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("bp.secondResult", 32'(resultA), 32'h069);
        outReadyA = 1'b1;
        @(negedge clk);
        outReadyA = 1'b0;

        // Reset one cycle after accept
        @(negedge clk);
        applyStimulus(0, 1'b1, 32'hAA, 32'h55);
        @(negedge clk);
        applyStimulus(0, 1'b0, 32'h00, 32'h00);
        checkOutput("midReset.wasBusy", 32'(busyA), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.inReady", 32'(inReadyA), 32'd1);
        checkOutput("midReset.outValid", 32'(outValidA), 32'd0);
        checkOutput("midReset.busy", 32'(busyA), 32'd0);
        checkOutput("midReset.result", 32'(resultA), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("midReset.noStale", 32'(outValidA), 32'd0);
        end
        runTrans(0, 32'h80, 32'h80, 32'h180, 3, "A_afterReset");

        // Exhaustive N=1, CHUNK=1 over the full-adder truth table
        for (int i = 0; i < 8; i++) begin
            logic a, b, ci, s1, c1;
            a  = i[2];
            b  = i[1];
            ci = i[0];
            s1 = a ^ b ^ ci;
            c1 = (a & b) | (a & ci) | (b & ci);
            runTrans(1, 32'(s1), 32'(c1), 32'(a) + 32'(b) + 32'(ci), 3, "B_fullAdder");
        end

        // Exhaustive N=4, CHUNK=16
        for (int s = 0; s < 16; s++) begin
            for (int c = 0; c < 16; c++) begin
                sv = 32'(s);
                cv = 32'(c);
                runTrans(2, sv, cv, sv + (cv << 1), 1, "C_exhaustive");
            end
        end

        // Random stress N=8, CHUNK=3 with random handshakes on both sides
        fork
            begin : driver
                int cyc;
                logic v;
                logic [7:0] s, c;
                cyc = 0;
                while (sent < 1000 && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    v = ($urandom_range(0, 3) != 0);
                    s = 8'($urandom);
                    c = 8'($urandom);
                    inValidD = v;
                    sumD = s;
                    carryD = c;
                    if (v && inReadyD) begin
                        expQ.push_back(10'(s) + (10'(c) << 1));
                        sent++;
                    end
                end
                @(negedge clk);
                inValidD = 1'b0;
            end
            begin : monitor
                int cyc;
                logic r;
                cyc = 0;
                while (received < 1000 && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    r = ($urandom_range(0, 2) != 0);
                    outReadyD = r;
                    if (r && outValidD) begin
                        checkOutput("stress.pending", 32'(expQ.size() > 0), 32'd1);
                        if (expQ.size() > 0)
                            checkOutput("stress.result", 32'(resultD), 32'(expQ.pop_front()));
                        received++;
                    end
                end
                @(negedge clk);
                outReadyD = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        checkOutput("stress.received", 32'(received), 32'd1000);
        checkOutput("stress.leftover", 32'(expQ.size()), 32'd0);
        checkOutput("stress.noExtra", 32'(outValidD), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/carry_save_resolver.md
Name: carry_save_resolver

Overview:
Converts a redundant carry-save pair (sum vector, carry vector) into a single binary result. The pair is what carry_save_adder_l2 produces, so this block is the consuming end of that interface. It uses a chunked carry-propagate adder that processes CHUNK bits per clock, trading latency for a short critical path. It sits after CSA trees in multi-operand adders and MAC datapaths, with valid/ready handshakes on both sides.

Parameters:
N, 8, width of the sum_vec and carry_vec inputs (N >= 1)
CHUNK, 4, bits resolved per clock cycle (CHUNK >= 1; any value, including CHUNK > N+2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operand pair
sum_vec  input  N  CSA sum vector; bit i has weight 2^i
carry_vec  input  N  CSA carry vector; bit i has weight 2^(i+1)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
result  output  N+2  sum_vec + (carry_vec << 1), zero-extended
busy  output  1  high in BUSY state

Behaviour:
- Working width W = N+2. K = ceil(W/CHUNK) chunks. Operands are zero-padded to K*CHUNK bits.
- Reset (async assert, sync release): state=IDLE. in_ready=1, out_valid=0, busy=0, result=0, chunk index=0, internal carry=0.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge:
    - latch opA = {0,0,sum_vec} and opB = {0,carry_vec,0};
    - clear the result register, set index=0 and cin=0;
    - go to BUSY.
  - in_valid low: stay in IDLE, no register changes.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle compute chunk[idx] = opA[idx] + opB[idx] + cin. Write the CHUNK-bit sum into result chunk idx, store the carry-out as the next cin, then increment idx.
  - When idx==K-1, move to DONE.
  - Exactly K cycles are spent in BUSY.
- DONE:
  - out_valid=1; result holds the final value.
  - in_ready=0; in_valid is ignored.
  - On out_ready=1 at a clock edge, go to IDLE. out_valid drops the next cycle.
  - No accept is allowed in the same cycle as the output handshake. The minimum initiation interval is K+2 cycles.
- Latency: for an accept edge at cycle t, out_valid is first high after edge t+K.
- Result stability: result, out_valid and the latched operands are held while out_valid=1 && out_ready=0. sum_vec and carry_vec may change freely after the accept edge.
- Arithmetic:
  - Unsigned. The maximum value 3*(2^N-1) fits in N+2 bits, so there is no overflow.
  - The carry-out of the top padded chunk is always 0.
  - Bits of the padded chunk above W are discarded.
- Partial results: result is not meaningful while busy=1. It is only defined when out_valid=1; no requirement is placed on it otherwise.
- Degenerate cases:
  - CHUNK >= W gives K=1: a single BUSY cycle.
  - N=1 matches the full-adder table. For example, a=1, b=0, c=1 presented as sum=0, carry=1 gives result=2.
- out_ready high in IDLE or BUSY has no effect.
- Reset asserted mid-BUSY or in DONE: the block returns to IDLE immediately (asynchronously) and out_valid clears. The transaction is lost, and no stale result may appear after release.
- Register every output; no combinational path from any input to any output.

Decomposition:
- Package carry_save_resolver_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - a constant function num_chunks(N, CHUNK) = ceil((N+2)/CHUNK);
  - a function giving the index counter width, clog2(K) with a minimum of 1.
- One sub-module, csr_chunk_adder: combinational CHUNK-bit adder with inputs a, b, cin and outputs s, cout. The FSM, counter and registers stay in the top level.

Test Plan:
- N=8, CHUNK=4: sum=8'hFF, carry=8'hFF -> result=10'h2FD. out_valid rises exactly 3 cycles after the accept edge; busy is high for those 3 cycles.
- N=8, CHUNK=4: sum=8'h0F, carry=8'h01 -> result=10'h011, proving the carry crosses the chunk 0→1 boundary. Then sum=0, carry=0 -> result=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, while driving in_valid=1 with new operands. result must stay constant, in_ready must stay 0, and the new pair is accepted only after returning to IDLE.
- Reset mid-BUSY: assert rst_n=0 one cycle after accept. in_ready=1, out_valid=0 and result=0 immediately. After release, a new pair (sum=8'h80, carry=8'h80 -> 10'h180) completes correctly.
- Parameter sweep with exhaustive inputs, compared against sum+(carry<<1):
  - N=1, CHUNK=1: all 8 full-adder input combinations; latency 3.
  - N=4, CHUNK=16: latency 1.
- Random stress, N=8, CHUNK=3: 1000 random pairs with random in_valid and out_ready. Scoreboard checks that no result is lost, none is duplicated, and every result is correct.
